// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared widths, FSM states and byte-lane helpers
// for the two-requester SRAM port arbiter.
package sram_port_arbiter_pkg;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, RMW_RD, RMW_MRG, RMW_WR} state_t;

   function automatic logic [DATA_W-1:0] byte_mask(input logic [BE_W-1:0] be);
      logic [DATA_W-1:0] m;
      for (int i = 0; i < BE_W; i++) m[i*8 +: 8] = {8{be[i]}};
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [BE_W-1:0] be);
      return (old_w & ~byte_mask(be)) | (new_w & byte_mask(be));
   endfunction
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: request/response handshake bundle for both requesters.
interface sram_port_arbiter_if;
   import sram_port_arbiter_pkg::*;
   logic              REQ_VALID0, REQ_READY0, REQ_WE0;
   logic [ADDR_W-1:0] REQ_ADDR0;
   logic [BE_W-1:0]   REQ_BE0;
   logic [DATA_W-1:0] REQ_WDATA0;
   logic              RSP_VALID0;
   logic [DATA_W-1:0] RSP_RDATA0;
   logic              REQ_VALID1, REQ_READY1, REQ_WE1;
   logic [ADDR_W-1:0] REQ_ADDR1;
   logic [BE_W-1:0]   REQ_BE1;
   logic [DATA_W-1:0] REQ_WDATA1;
   logic              RSP_VALID1;
   logic [DATA_W-1:0] RSP_RDATA1;

   modport master (
      output REQ_VALID0, REQ_WE0, REQ_ADDR0, REQ_BE0, REQ_WDATA0,
      output REQ_VALID1, REQ_WE1, REQ_ADDR1, REQ_BE1, REQ_WDATA1,
      input  REQ_READY0, RSP_VALID0, RSP_RDATA0,
      input  REQ_READY1, RSP_VALID1, RSP_RDATA1
   );

   modport slave (
      input  REQ_VALID0, REQ_WE0, REQ_ADDR0, REQ_BE0, REQ_WDATA0,
      input  REQ_VALID1, REQ_WE1, REQ_ADDR1, REQ_BE1, REQ_WDATA1,
      output REQ_READY0, RSP_VALID0, RSP_RDATA0,
      output REQ_READY1, RSP_VALID1, RSP_RDATA1
   );
endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// sram_rr_arb2: two-way round-robin grant; a tie goes to whoever was not granted last.
module sram_rr_arb2 (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic valid0,
   input  logic valid1,
   output logic gnt0,
   output logic gnt1
);
   logic last_gnt;
   logic pick1;

   assign pick1 = valid1 && (!valid0 || !last_gnt);
   assign gnt1  = en && pick1;
   assign gnt0  = en && valid0 && !pick1;

   always_ff @(posedge CLK)
      last_gnt <= RST ? 1'b1 : (gnt0 || gnt1) ? gnt1 : last_gnt;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between two requesters, turning
// partial-byte writes into read-modify-write and routing in-order responses.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   sram_port_arbiter_if.slave bus,
   output logic              CSN,
   output logic [ADDR_W-1:0] ADDR,
   output logic              WE,
   output logic [BE_W-1:0]   BE,
   output logic [DATA_W-1:0] DI,
   input  logic [DATA_W-1:0] DO
);
   state_t            state;
   logic              gnt0, gnt1, acc, own;
   logic              a_we, a_nz, a_full, a_part;
   logic [ADDR_W-1:0] a_addr;
   logic [BE_W-1:0]   a_be;
   logic [DATA_W-1:0] a_wdata;
   logic              s1_v, s1_own, s1_rd, s2_v, s2_own, s2_rd;
   logic [BE_W-1:0]   s1_be, s2_be, rmw_be;
   logic              rmw_own;
   logic [DATA_W-1:0] rmw_wdata;

   sram_rr_arb2 u_arb (
      .CLK    (CLK),
      .RST    (RST),
      .en     (state == IDLE && !RST),
      .valid0 (bus.REQ_VALID0),
      .valid1 (bus.REQ_VALID1),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   assign bus.REQ_READY0 = gnt0;
   assign bus.REQ_READY1 = gnt1;
   assign acc     = gnt0 || gnt1;
   assign own     = gnt1;
   assign a_we    = own ? bus.REQ_WE1 : bus.REQ_WE0;
   assign a_addr  = own ? bus.REQ_ADDR1 : bus.REQ_ADDR0;
   assign a_be    = own ? bus.REQ_BE1 : bus.REQ_BE0;
   assign a_wdata = own ? bus.REQ_WDATA1 : bus.REQ_WDATA0;
   assign a_nz    = |a_be;
   assign a_full  = &a_be;
   assign a_part  = a_we && a_nz && !a_full;

   // Stage 1 covers the SRAM access cycle, stage 2 the cycle DO is valid;
   // an RMW injects its completion into stage 2 as it leaves RMW_WR.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         CSN       <= 1'b1;
         WE        <= 1'b0;
         BE        <= '0;
         ADDR      <= '0;
         DI        <= '0;
         s1_v      <= 1'b0;
         s1_own    <= 1'b0;
         s1_rd     <= 1'b0;
         s1_be     <= '0;
         s2_v      <= 1'b0;
         s2_own    <= 1'b0;
         s2_rd     <= 1'b0;
         s2_be     <= '0;
         rmw_own   <= 1'b0;
         rmw_be    <= '0;
         rmw_wdata <= '0;
      end else begin
         s1_v   <= acc && !a_part;
         s1_own <= own;
         s1_rd  <= !a_we && a_nz;
         s1_be  <= a_be;
         s2_v   <= s1_v || state == RMW_WR;
         s2_own <= state == RMW_WR ? rmw_own : s1_own;
         s2_rd  <= s1_rd && state != RMW_WR;
         s2_be  <= s1_be;
         case (state)
            IDLE: begin
               CSN   <= !(acc && a_nz);
               WE    <= acc && a_we && a_full;
               state <= acc && a_part ? RMW_RD : IDLE;
               if (acc) begin
                  ADDR      <= a_addr;
                  BE        <= '1;
                  DI        <= a_wdata;
                  rmw_own   <= own;
                  rmw_be    <= a_be;
                  rmw_wdata <= a_wdata;
               end
            end
            RMW_RD: begin
               CSN   <= 1'b1;
               state <= RMW_MRG;
            end
            RMW_MRG: begin
               CSN   <= 1'b0;
               WE    <= 1'b1;
               DI    <= merge_bytes(DO, rmw_wdata, rmw_be);
               state <= RMW_WR;
            end
            RMW_WR: begin
               CSN   <= 1'b1;
               WE    <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.RSP_VALID0 = s2_v && !s2_own;
   assign bus.RSP_VALID1 = s2_v && s2_own;
   assign bus.RSP_RDATA0 = bus.RSP_VALID0 && s2_rd ? DO & byte_mask(s2_be) : '0;
   assign bus.RSP_RDATA1 = bus.RSP_VALID1 && s2_rd ? DO & byte_mask(s2_be) : '0;
endmodule
